// File: rtl/mmu_bat_sched.sv
// Time-shares one external BAT check datapath between instruction and data lookups,
// and holds the IBAT/DBAT register banks that feed it.
module mmu_bat_sched #(
    parameter int NR_BATS = 4,
    parameter int REGSZ   = 32
) (
    input  logic                        clk,
    input  logic                        reset,

    // Handshake rule on every channel: transfer happens on the rising edge where
    // valid && ready; the source holds its payload until that edge.
    input  logic                        i_req_valid,
    output logic                        i_req_ready,
    input  logic [REGSZ-1:0]            i_vaddr,
    input  logic                        i_priv,

    input  logic                        d_req_valid,
    output logic                        d_req_ready,
    input  logic [REGSZ-1:0]            d_vaddr,
    input  logic                        d_priv,
    input  logic                        d_RnW,

    input  logic                        spr_wr,
    input  logic [$clog2(NR_BATS)+1:0]  spr_idx,
    input  logic [31:0]                 spr_wdata,

    output logic [REGSZ-1:0]            bat_vaddr,
    output logic                        bat_priv,
    output logic                        bat_RnW,
    output logic [64*NR_BATS-1:0]       bat_bats,
    input  logic [REGSZ-1:0]            bat_paddr,
    input  logic                        bat_cacheable,
    input  logic [2:0]                  bat_fault,
    input  logic                        bat_valid,

    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic                        resp_side,
    output logic [REGSZ-1:0]            resp_paddr,
    output logic                        resp_cacheable,
    output logic [2:0]                  resp_fault,
    output logic                        resp_hit,

    output logic [1:0]                  state_dbg
);

    localparam int NW = $clog2(NR_BATS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t           state;
    logic             last_d;
    logic             side_q;
    logic [REGSZ-1:0] vaddr_q;
    logic             priv_q;
    logic             rnw_q;

    logic [63:0]      ibat [NR_BATS];
    logic [63:0]      dbat [NR_BATS];

    logic             spr_bank;
    logic [NW-1:0]    spr_num;
    logic             spr_half;
    logic             can_accept;
    logic             grant_i;
    logic             grant_d;

    assign spr_bank = spr_idx[NW+1];
    assign spr_num  = spr_idx[NW:1];
    assign spr_half = spr_idx[0];

    // Round-robin: on a tie the side that was not granted last wins.
    assign grant_i    = i_req_valid && (!d_req_valid || last_d);
    assign grant_d    = d_req_valid && (!i_req_valid || !last_d);
    assign can_accept = (state == ST_IDLE) && !spr_wr && !reset;

    assign i_req_ready = can_accept && grant_i;
    assign d_req_ready = can_accept && grant_d;

    assign bat_vaddr = vaddr_q;
    assign bat_priv  = priv_q;
    assign bat_RnW   = rnw_q;
    assign state_dbg = state;

    always_comb begin
        bat_bats = '0;
        for (int n = 0; n < NR_BATS; n++) begin
            bat_bats[64*n +: 64] = side_q ? dbat[n] : ibat[n];
        end
    end

    // Half 0 is the upper word, half 1 the lower word of each BAT pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NR_BATS; n++) begin
                ibat[n] <= '0;
                dbat[n] <= '0;
            end
        end else if (spr_wr) begin
            if (spr_bank) begin
                if (spr_half) dbat[spr_num][31:0]  <= spr_wdata;
                else          dbat[spr_num][63:32] <= spr_wdata;
            end else begin
                if (spr_half) ibat[spr_num][31:0]  <= spr_wdata;
                else          ibat[spr_num][63:32] <= spr_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            last_d         <= 1'b1;
            side_q         <= 1'b0;
            vaddr_q        <= '0;
            priv_q         <= 1'b0;
            rnw_q          <= 1'b0;
            resp_valid     <= 1'b0;
            resp_side      <= 1'b0;
            resp_paddr     <= '0;
            resp_cacheable <= 1'b0;
            resp_fault     <= 3'd0;
            resp_hit       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req_ready) begin
                        vaddr_q <= i_vaddr;
                        priv_q  <= i_priv;
                        rnw_q   <= 1'b1;
                        side_q  <= 1'b0;
                        last_d  <= 1'b0;
                        state   <= ST_LOOKUP;
                    end else if (d_req_ready) begin
                        vaddr_q <= d_vaddr;
                        priv_q  <= d_priv;
                        rnw_q   <= d_RnW;
                        side_q  <= 1'b1;
                        last_d  <= 1'b1;
                        state   <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    // A miss reports all-zero translation fields regardless of datapath output.
                    resp_valid     <= 1'b1;
                    resp_side      <= side_q;
                    resp_hit       <= bat_valid;
                    resp_paddr     <= bat_valid ? bat_paddr : '0;
                    resp_cacheable <= bat_valid && bat_cacheable;
                    resp_fault     <= bat_valid ? bat_fault : 3'd0;
                    state          <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_bat_sched.sv
// Directed bench for mmu_bat_sched: a behavioural BAT check datapath, driver tasks,
// and a scoreboard monitor that pops expected responses on every resp handshake.
module tb_mmu_bat_sched;

    localparam int NR_BATS = 4;
    localparam int REGSZ   = 32;
    localparam int W       = 38;
    localparam logic [2:0] F_NONE = 3'd0;
    localparam logic [2:0] F_MISS = 3'd1;
    localparam logic [2:0] F_PF   = 3'd2;

    logic                      clk;
    logic                      reset;
    logic                      i_req_valid, i_req_ready, i_priv;
    logic [REGSZ-1:0]          i_vaddr;
    logic                      d_req_valid, d_req_ready, d_priv, d_RnW;
    logic [REGSZ-1:0]          d_vaddr;
    logic                      spr_wr;
    logic [$clog2(NR_BATS)+1:0] spr_idx;
    logic [31:0]               spr_wdata;
    logic [REGSZ-1:0]          bat_vaddr, bat_paddr;
    logic                      bat_priv, bat_RnW, bat_cacheable, bat_valid;
    logic [64*NR_BATS-1:0]     bat_bats;
    logic [2:0]                bat_fault;
    logic                      resp_valid, resp_ready, resp_side, resp_cacheable, resp_hit;
    logic [REGSZ-1:0]          resp_paddr;
    logic [2:0]                resp_fault;
    logic [1:0]                state_dbg;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;

    mmu_bat_sched #(.NR_BATS(NR_BATS), .REGSZ(REGSZ)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_vaddr(i_vaddr), .i_priv(i_priv),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_vaddr(d_vaddr), .d_priv(d_priv),
        .d_RnW(d_RnW),
        .spr_wr(spr_wr), .spr_idx(spr_idx), .spr_wdata(spr_wdata),
        .bat_vaddr(bat_vaddr), .bat_priv(bat_priv), .bat_RnW(bat_RnW), .bat_bats(bat_bats),
        .bat_paddr(bat_paddr), .bat_cacheable(bat_cacheable), .bat_fault(bat_fault),
        .bat_valid(bat_valid),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_side(resp_side),
        .resp_paddr(resp_paddr), .resp_cacheable(resp_cacheable), .resp_fault(resp_fault),
        .resp_hit(resp_hit), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- BAT datapath model (U: BEPI/BL/Vs/Vp, L: BRPN/WIMG/PP) ----------------
    logic [31:0] bu, bl;
    logic [14:0] blm;
    always_comb begin
        bat_valid = 1'b0; bat_paddr = bat_vaddr; bat_cacheable = 1'b1; bat_fault = F_MISS;
        bu = '0; bl = '0; blm = '0;
        for (int n = NR_BATS-1; n >= 0; n--) begin
            bu  = bat_bats[64*n+32 +: 32];
            bl  = bat_bats[64*n +: 32];
            blm = {4'b0, bu[12:2]};
            if ((bat_priv ? bu[1] : bu[0]) && ((bat_vaddr[31:17] & ~blm) == bu[31:17])) begin
                bat_valid     = 1'b1;
                bat_paddr     = {bl[31:17] | (bat_vaddr[31:17] & blm), bat_vaddr[16:0]};
                bat_cacheable = !bl[5];
                bat_fault     = (bl[1:0] == 2'b00 || (bl[0] && !bat_RnW)) ? F_PF : F_NONE;
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] mk(input logic side, input logic hit, input logic [31:0] pa,
                                        input logic c, input logic [2:0] f);
        return {side, hit, pa, c, f};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp_unexpected: got side=%0d paddr=%h with empty expected queue",
                         resp_side, resp_paddr);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_side",      64'(resp_side),      64'(mon_e[37]));
                check("resp_hit",       64'(resp_hit),       64'(mon_e[36]));
                check("resp_paddr",     64'(resp_paddr),     64'(mon_e[35:4]));
                check("resp_cacheable", 64'(resp_cacheable), 64'(mon_e[3]));
                check("resp_fault",     64'(resp_fault),     64'(mon_e[2:0]));
            end
        end
    end

    // ---------------- driver tasks (enter and leave 1 time unit after a rising edge) ----------------
    task automatic spr_write(input logic bank, input logic [1:0] num, input logic half,
                             input logic [31:0] data);
        spr_wr = 1'b1; spr_idx = {bank, num, half}; spr_wdata = data;
        @(posedge clk); #1;
        spr_wr = 1'b0;
    endtask

    task automatic lookup(input logic side, input logic [31:0] va, input logic priv,
                          input logic rnw, input logic [W-1:0] exp);
        bit got = 0;
        if (side) begin d_req_valid = 1'b1; d_vaddr = va; d_priv = priv; d_RnW = rnw; end
        else      begin i_req_valid = 1'b1; i_vaddr = va; i_priv = priv; end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (side ? d_req_ready : i_req_ready) begin
                got = 1;
                exp_q.push_back(exp);
            end
            @(posedge clk); #1;
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL lookup_accept: got no ready expected ready within 20 cycles");
        end
    endtask

    task automatic rr_run(input int n, input logic [W-1:0] exp_i, input logic [W-1:0] exp_d);
        int acc = 0;
        i_req_valid = 1'b1; d_req_valid = 1'b1;
        for (int k = 0; k < 20*n && acc < n; k++) begin
            @(negedge clk);
            if (i_req_ready || d_req_ready) begin
                exp_q.push_back((acc % 2 == 0) ? exp_i : exp_d);
                acc++;
            end
            @(posedge clk); #1;
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        check("rr_accepts", 64'(acc), 64'(n));
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && state_dbg == 2'd0) done = 1;
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; resp_ready = 1'b1; spr_wr = 1'b0; spr_idx = '0; spr_wdata = '0;
        i_req_valid = 1'b1; i_vaddr = '0; i_priv = 1'b0;
        d_req_valid = 1'b1; d_vaddr = '0; d_priv = 1'b0; d_RnW = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_i_ready",    64'(i_req_ready), 64'd0);
        check("rst_d_ready",    64'(d_req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid),  64'd0);
        check("rst_resp_paddr", 64'(resp_paddr),  64'd0);
        check("rst_resp_flags", 64'({resp_hit, resp_cacheable, resp_fault, resp_side}), 64'd0);
        check("rst_state",      64'(state_dbg),   64'd0);
        check("rst_bats_zero",  64'(bat_bats == '0), 64'd1);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        reset = 1'b0;

        // Miss straight after reset; hold the response with resp_ready low.
        resp_ready = 1'b0;
        i_vaddr = 32'h8000_0000; i_priv = 1'b1;
        @(negedge clk);
        check("first_ready", 64'(i_req_ready), 64'd1);
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 3'd0));
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        @(negedge clk);
        check("latency_n1_valid", 64'(resp_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_paddr", 64'(resp_paddr), 64'd0);
            check("hold_flags", 64'({resp_side, resp_hit, resp_cacheable, resp_fault}), 64'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        wait_idle();

        spr_write(1'b0, 2'd0, 1'b0, 32'h0000_0003);
        spr_write(1'b0, 2'd0, 1'b1, 32'h0010_0002);
        spr_write(1'b1, 2'd0, 1'b0, 32'h0000_0003);
        spr_write(1'b1, 2'd0, 1'b1, 32'h0010_0001);

        d_RnW = 1'b0;
        lookup(1'b0, 32'h0000_1234, 1'b1, 1'b0, mk(1'b0, 1'b1, 32'h0010_1234, 1'b1, F_NONE));
        check("i_rnw_forced", 64'(bat_RnW),   64'd1);
        check("i_bat_vaddr",  64'(bat_vaddr), 64'h1234);
        wait_idle();
        lookup(1'b1, 32'h0000_0010, 1'b1, 1'b0, mk(1'b1, 1'b1, 32'h0010_0010, 1'b1, F_PF));
        wait_idle();
        lookup(1'b1, 32'h0000_0010, 1'b1, 1'b1, mk(1'b1, 1'b1, 32'h0010_0010, 1'b1, F_NONE));
        wait_idle();

        // DBAT3: privileged-only, cache-inhibited block at 0x1000_0000 -> 0x0A00_0000.
        spr_write(1'b1, 2'd3, 1'b0, 32'h1000_0002);
        spr_write(1'b1, 2'd3, 1'b1, 32'h0A00_0022);
        lookup(1'b1, 32'h1000_0ABC, 1'b1, 1'b1, mk(1'b1, 1'b1, 32'h0A00_0ABC, 1'b0, F_NONE));
        wait_idle();
        lookup(1'b1, 32'h1000_0ABC, 1'b0, 1'b1, mk(1'b1, 1'b0, 32'h0, 1'b0, 3'd0));
        wait_idle();

        // Tie arbitration after a D grant: I, D, I, D.
        i_vaddr = 32'h0000_2000; i_priv = 1'b1;
        d_vaddr = 32'h0000_0020; d_priv = 1'b1; d_RnW = 1'b1;
        rr_run(4, mk(1'b0, 1'b1, 32'h0010_2000, 1'b1, F_NONE),
                  mk(1'b1, 1'b1, 32'h0010_0020, 1'b1, F_NONE));
        wait_idle();

        // BAT write landing in the LOOKUP cycle must not affect that result.
        lookup(1'b0, 32'h0000_1234, 1'b1, 1'b1, mk(1'b0, 1'b1, 32'h0010_1234, 1'b1, F_NONE));
        spr_write(1'b0, 2'd0, 1'b1, 32'h0020_0002);
        wait_idle();
        lookup(1'b0, 32'h0000_1234, 1'b1, 1'b1, mk(1'b0, 1'b1, 32'h0020_1234, 1'b1, F_NONE));
        wait_idle();

        // BAT write and D request in the same IDLE cycle: write first, request next cycle.
        spr_wr = 1'b1; spr_idx = {1'b1, 2'd0, 1'b1}; spr_wdata = 32'h0030_0002;
        d_req_valid = 1'b1; d_vaddr = 32'h0000_0040; d_priv = 1'b0; d_RnW = 1'b1;
        @(negedge clk);
        check("spr_blocks_ready", 64'(d_req_ready), 64'd0);
        @(posedge clk); #1;
        spr_wr = 1'b0;
        @(negedge clk);
        check("ready_after_spr", 64'(d_req_ready), 64'd1);
        exp_q.push_back(mk(1'b1, 1'b1, 32'h0030_0040, 1'b1, F_NONE));
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        wait_idle();

        // Reset while a lookup is in flight.
        d_req_valid = 1'b1; d_vaddr = 32'h0000_0010; d_priv = 1'b1; d_RnW = 1'b1;
        @(negedge clk);
        check("pre_rst_ready", 64'(d_req_ready), 64'd1);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        check("pre_rst_lookup", 64'(state_dbg), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_lookup_state", 64'(state_dbg), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_no_resp", 64'(resp_valid), 64'd0);
            @(posedge clk); #1;
        end
        check("rst_ibats_zero", 64'(bat_bats == '0), 64'd1);
        i_vaddr = 32'h0000_1234; d_vaddr = 32'h0000_0010;
        rr_run(2, mk(1'b0, 1'b0, 32'h0, 1'b0, 3'd0), mk(1'b1, 1'b0, 32'h0, 1'b0, 3'd0));
        wait_idle();
        lookup(1'b1, 32'h0000_0010, 1'b1, 1'b1, mk(1'b1, 1'b0, 32'h0, 1'b0, 3'd0));
        check("rst_dbats_zero", 64'(bat_bats == '0), 64'd1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmu_bat_sched.md
MMU_BAT_SCHED -- requirements
Module: mmu_bat_sched

Interface
REQ-001 Parameter NR_BATS, default 4, BAT pairs per bank (IBAT and DBAT); SHALL be a power of two, 2..8.
REQ-002 Parameter REGSZ, default 32, address width.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 i_req_valid/i_req_ready  in/out  1/1  instruction-side lookup handshake.
REQ-006 i_vaddr  in  REGSZ  I-side effective address; i_priv  in  1  I-side privileged.
REQ-007 d_req_valid/d_req_ready  in/out  1/1  data-side lookup handshake.
REQ-008 d_vaddr  in  REGSZ; d_priv  in  1; d_RnW  in  1  D-side address, privilege, 1=read.
REQ-009 spr_wr  in  1  BAT register write strobe; spr_idx  in  1+log2(NR_BATS)+1  {bank(1=D), BAT number, half(0=U,1=L)}; spr_wdata  in  32.
REQ-010 bat_vaddr/bat_priv/bat_RnW  out  REGSZ/1/1  request driven to the shared BAT check datapath (INSTRUCTION=0 variant).
REQ-011 bat_bats  out  64*NR_BATS  selected bank, BAT n at [64n+63:64n+32]=U, [64n+31:64n]=L.
REQ-012 bat_paddr/bat_cacheable/bat_fault/bat_valid  in  REGSZ/1/3/1  combinational datapath result.
REQ-013 resp_valid  out 1; resp_ready  in 1; resp_side  out 1 (1=D); resp_paddr  out REGSZ; resp_cacheable  out 1; resp_fault  out 3; resp_hit  out 1.

Function
REQ-014 The block SHALL hold 2*NR_BATS 64-bit BAT registers and SHALL time-share one BAT datapath between I and D requesters.
REQ-015 FSM states IDLE, LOOKUP, RESP; IDLE->LOOKUP on request accept; LOOKUP->RESP unconditionally; RESP->IDLE on resp_valid&&resp_ready.
REQ-016 i_req_ready/d_req_ready SHALL be asserted only in IDLE with spr_wr low, and only for the granted side.
REQ-017 Arbitration: single requester wins; both valid -> the side not granted last SHALL win (round-robin); last-grant flag resets to D so I wins first tie.
REQ-018 On accept, vaddr, priv, RnW (forced to 1 for I-side) and side SHALL be registered; bat_* outputs SHALL be driven from these registers and bat_bats SHALL select the bank matching the registered side.
REQ-019 In LOOKUP the datapath result SHALL be captured into resp_* registers; resp_hit = bat_valid; resp_paddr/resp_cacheable/resp_fault SHALL be forced to 0 when bat_valid=0.
REQ-020 Latency: accept in cycle N -> resp_valid high in cycle N+2.
REQ-021 resp_* SHALL remain stable while resp_valid && !resp_ready.
REQ-022 spr_wr SHALL be accepted in any state and update the addressed 32-bit half at the clock edge; the write is visible from the next cycle.
REQ-023 A write during LOOKUP SHALL NOT affect the result captured that cycle (pre-write value used).
REQ-024 spr_wr and a pending request in IDLE: write wins, no request accepted that cycle.
REQ-025 spr_idx bits beyond the implemented bank/number range SHALL be ignored (no write).

Reset
REQ-026 reset SHALL force state IDLE, all BAT registers 0, resp_valid 0, all resp_* 0, last-grant D, any in-flight lookup discarded.
REQ-027 Ready outputs SHALL be 0 while reset is asserted; first accept is possible in the first cycle after deassertion.

Verification
REQ-028 IBAT0U=0x00000003, IBAT0L=0x00100002, I lookup vaddr 0x00001234 priv=1 -> two cycles later resp_valid=1, side=0, hit=1, paddr=0x00101234, cacheable=1, fault=NONE.
REQ-029 DBAT0U=0x00000003, DBAT0L=0x00100001, D write (RnW=0) vaddr 0x00000010 -> hit=1, fault=MMU_FAULT_PF; same with RnW=1 -> fault=NONE.
REQ-030 I and D valid together for 4 consecutive accepts with resp_ready=1 -> grant order I,D,I,D.
REQ-031 Lookup after reset with no BAT writes, vaddr 0x80000000 -> hit=0, paddr=0, fault=0; resp held 3 cycles with resp_ready=0, values unchanged.
REQ-032 spr_wr asserted same cycle as d_req_valid in IDLE -> d_req_ready=0 that cycle, request accepted next cycle using new BAT value.
REQ-033 reset asserted in LOOKUP -> resp_valid never rises, state IDLE, all BAT registers read back 0.
